// File: rtl/lsu_mem_if_pkg.sv
// Shared definitions for the load/store unit memory interface:
// load-type encodings, FSM state encoding and the accept-time legality check.
package lsu_mem_if_pkg;

  // Load types; must match the control unit's LAddr encoding.
  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LB  = 3'b001,
    LT_LBU = 3'b010,
    LT_LH  = 3'b011,
    LT_LHU = 3'b100
  } ltype_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // A request is illegal when its ltype is unknown (loads only) or when the
  // address is not naturally aligned for the access size. Stores are words.
  function automatic logic req_err(input logic       we,
                                   input logic [2:0] ltype,
                                   input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    if (we) begin
      err = (addr_lo != 2'b00);
    end else begin
      case (ltype)
        LT_LW:         err = (addr_lo != 2'b00);
        LT_LB, LT_LBU: err = 1'b0;
        LT_LH, LT_LHU: err = addr_lo[0];
        default:       err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_mem_if_load_ext.sv
// Little-endian byte/halfword selection with sign or zero extension.
module load_ext
  import lsu_mem_if_pkg::*;
(
  input  logic [2:0]  ltype,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the word.
  always_comb begin
    case (addr)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = 8'd0;
    endcase
    if (addr[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extend the selected field according to the load type; unknown types read 0.
  always_comb begin
    case (ltype)
      LT_LW:   data = word;
      LT_LB:   data = {{24{byte_s[7]}}, byte_s};
      LT_LBU:  data = {24'd0, byte_s};
      LT_LH:   data = {{16{half_s[15]}}, half_s};
      LT_LHU:  data = {16'd0, half_s};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit memory interface: accepts one request at a time in IDLE,
// performs a single word access on the memory port with a bounded wait,
// and returns a one-cycle response. Illegal requests skip the memory.
module lsu_mem_if
  import lsu_mem_if_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ltype,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          we_q, we_d;
  logic [2:0]    ltype_q, ltype_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          stall_q, stall_d;
  logic          req_ready_q, req_ready_d;

  logic          acc_err_s;
  logic          timeout_s;
  logic [31:0]   ext_data_s;

  assign acc_err_s = req_err(req_we, req_ltype, req_addr[1:0]);
  assign timeout_s = (wait_q == WW'(MAX_WAIT - 1));

  load_ext u_load_ext (
    .ltype (ltype_q),
    .addr  (addr_lo_q),
    .word  (mem_rdata),
    .data  (ext_data_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unknown encodings fall back to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (acc_err_s) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mem_ack || timeout_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and latched request fields.
  always_comb begin
    we_d         = we_q;
    ltype_d      = ltype_q;
    addr_lo_d    = addr_lo_q;
    wait_d       = wait_q;
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    stall_d      = (state_d != ST_IDLE);
    req_ready_d  = (state_d == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          ltype_d     = req_ltype;
          addr_lo_d   = req_addr[1:0];
          wait_d      = {WW{1'b0}};
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_wdata_d = req_wdata;
          if (acc_err_s) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_req_d = 1'b1;
            mem_we_d  = req_we;
          end
        end else begin
          wait_d = {WW{1'b0}};
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          // An ack in the final wait cycle still completes without error.
          resp_valid_d = 1'b1;
          if (we_q) begin
            resp_rdata_d = 32'd0;
          end else begin
            resp_rdata_d = ext_data_s;
          end
        end else if (timeout_s) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          wait_d       = wait_q + WW'(1);
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = we_q;
          wait_d    = wait_q + WW'(1);
        end
      end
      ST_RESP: begin
        wait_d = {WW{1'b0}};
      end
      default: begin
        wait_d = {WW{1'b0}};
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      we_q         <= 1'b0;
      ltype_q      <= 3'd0;
      addr_lo_q    <= 2'd0;
      wait_q       <= {WW{1'b0}};
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      stall_q      <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      we_q         <= we_d;
      ltype_q      <= ltype_d;
      addr_lo_q    <= addr_lo_d;
      wait_q       <= wait_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      stall_q      <= stall_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign stall      = stall_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
